// File: rtl/hsv_div_scheduler.sv
// RGB -> HSV pixel stage: computes max/min/delta locally and sequences the hue
// and saturation divisions onto one shared iterative divider (start/done).
module hsv_div_scheduler #(
  parameter int TIMEOUT_CYC = 64,
  parameter int HUE_SCALE   = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  din_r,
  input  logic [7:0]  din_g,
  input  logic [7:0]  din_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  dout_h,
  output logic [7:0]  dout_s,
  output logic [7:0]  dout_v,
  output logic        div_start,
  output logic [15:0] div_dividend,
  output logic [7:0]  div_divisor,
  input  logic        div_done,
  input  logic [15:0] div_quotient,
  output logic        busy,
  output logic        err_timeout,
  input  logic        err_clr,
  output logic [15:0] pix_cnt
);

  // Handshakes: a transfer occurs on a rising clk edge with valid && ready high;
  // the source holds its data stable while valid && !ready, and valid never
  // depends combinationally on ready.
  typedef enum logic [2:0] {
    IDLE, PREP, ISSUE_H, WAIT_H, ISSUE_S, WAIT_S, OUT
  } state_t;

  state_t state, state_nxt;

  logic [7:0]        r_q, g_q, b_q, max_q, delta_q, base_q;
  logic              neg_q, ready_armed;
  logic [15:0]       tcnt;
  logic [7:0]        max_c, min_c, delta_c, base_c, quot;
  logic signed [8:0] num_c;
  logic [8:0]        abs_num;
  logic [9:0]        h_raw;
  logic [7:0]        h_fix;
  logic              accept, in_wait, timeout_hit;

  // Max select priority R > G > B on ties; numerator/base follow the winner.
  always_comb begin
    max_c  = b_q;
    base_c = 8'd120;
    num_c  = $signed({1'b0, r_q}) - $signed({1'b0, g_q});
    if (r_q >= g_q && r_q >= b_q) begin
      max_c  = r_q;
      base_c = 8'd0;
      num_c  = $signed({1'b0, g_q}) - $signed({1'b0, b_q});
    end else if (g_q >= b_q) begin
      max_c  = g_q;
      base_c = 8'd60;
      num_c  = $signed({1'b0, b_q}) - $signed({1'b0, r_q});
    end
    min_c = r_q;
    if (g_q < min_c) min_c = g_q;
    if (b_q < min_c) min_c = b_q;
    delta_c = max_c - min_c;
    abs_num = num_c[8] ? $unsigned(-num_c) : $unsigned(num_c);
  end

  // Legal operands keep the quotient within 8 bits; clamp guards a faulty divider.
  assign quot  = (|div_quotient[15:8]) ? 8'hFF : div_quotient[7:0];
  assign h_raw = neg_q ? ({2'b00, base_q} - {2'b00, quot})
                       : ({2'b00, base_q} + {2'b00, quot});
  assign h_fix = h_raw[9] ? 8'(h_raw + 10'd180) : h_raw[7:0];

  assign accept      = in_valid & in_ready;
  assign in_wait     = (state == WAIT_H) || (state == WAIT_S);
  assign timeout_hit = in_wait && !div_done && (tcnt == 16'(TIMEOUT_CYC - 1));

  assign in_ready  = ready_armed && (state == IDLE);
  assign out_valid = (state == OUT);
  assign busy      = (state != IDLE);
  assign div_start = (state == ISSUE_H) || (state == ISSUE_S);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = PREP;
      PREP:    state_nxt = (delta_c == 8'd0) ? OUT : ISSUE_H;
      ISSUE_H: state_nxt = WAIT_H;
      WAIT_H:  if (div_done) state_nxt = ISSUE_S;
               else if (timeout_hit) state_nxt = OUT;
      ISSUE_S: state_nxt = WAIT_S;
      WAIT_S:  if (div_done || timeout_hit) state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_armed  <= 1'b0;
      r_q          <= '0;
      g_q          <= '0;
      b_q          <= '0;
      max_q        <= '0;
      delta_q      <= '0;
      base_q       <= '0;
      neg_q        <= 1'b0;
      tcnt         <= '0;
      dout_h       <= '0;
      dout_s       <= '0;
      dout_v       <= '0;
      div_dividend <= '0;
      div_divisor  <= '0;
      pix_cnt      <= '0;
    end else begin
      ready_armed <= 1'b1;
      case (state)
        IDLE: if (accept) begin
          r_q <= din_r;
          g_q <= din_g;
          b_q <= din_b;
        end
        PREP: begin
          max_q   <= max_c;
          delta_q <= delta_c;
          base_q  <= base_c;
          neg_q   <= num_c[8];
          dout_v  <= max_c;
          if (delta_c == 8'd0) begin
            dout_h <= '0;
            dout_s <= '0;
          end else begin
            div_dividend <= 16'(abs_num[7:0]) * 16'(HUE_SCALE);
            div_divisor  <= delta_c;
          end
        end
        ISSUE_H, ISSUE_S: tcnt <= '0;
        WAIT_H: begin
          if (div_done) begin
            dout_h       <= h_fix;
            div_dividend <= 16'(delta_q) * 16'd255;
            div_divisor  <= max_q;
          end else if (timeout_hit) begin
            dout_h <= '0;
            dout_s <= '0;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
        WAIT_S: begin
          if (div_done) begin
            dout_s <= quot;
          end else if (timeout_hit) begin
            dout_h <= '0;
            dout_s <= '0;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
        OUT: if (out_ready) pix_cnt <= pix_cnt + 16'd1;
        default: ;
      endcase
    end
  end

  // Sticky error: a new timeout outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           err_timeout <= 1'b0;
    else if (timeout_hit) err_timeout <= 1'b1;
    else if (err_clr)     err_timeout <= 1'b0;
  end

endmodule

// File: tb/tb_hsv_div_scheduler.sv
// Self-checking bench for hsv_div_scheduler: directed colours, timeout, reset
// abort and randomized pixels against an arithmetic HSV reference.
module tb_hsv_div_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  din_r = '0, din_g = '0, din_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  dout_h, dout_s, dout_v;
  logic        div_start;
  logic [15:0] div_dividend;
  logic [7:0]  div_divisor;
  logic        div_done = 1'b0;
  logic [15:0] div_quotient = '0;
  logic        busy;
  logic        err_timeout;
  logic        err_clr = 1'b0;
  logic [15:0] pix_cnt;

  int n_chk = 0;
  int n_pass = 0;
  int exp_cnt = 0;
  logic [23:0] exp_q[$];

  // divider responder state
  int          div_lat = 4;
  bit          div_en = 1'b1;
  int          pend = 0;
  logic [15:0] pend_q = '0;
  int          bad_div = 0;
  logic [15:0] st_dd[$];
  logic [7:0]  st_dv[$];

  hsv_div_scheduler #(.TIMEOUT_CYC(64), .HUE_SCALE(30)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .din_r(din_r), .din_g(din_g), .din_b(din_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .dout_h(dout_h), .dout_s(dout_s), .dout_v(dout_v),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_done(div_done), .div_quotient(div_quotient),
    .busy(busy), .err_timeout(err_timeout), .err_clr(err_clr),
    .pix_cnt(pix_cnt)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // Behavioural shared divider: answers each start pulse div_lat cycles later.
  always @(negedge clk) begin
    div_done = 1'b0;
    if (pend > 0) begin
      pend = pend - 1;
      if (pend == 0) begin
        div_done     = 1'b1;
        div_quotient = pend_q;
      end
    end
    if (div_start === 1'b1) begin
      st_dd.push_back(div_dividend);
      st_dv.push_back(div_divisor);
      if (div_divisor == 8'd0) bad_div = bad_div + 1;
      if (div_en) begin
        pend   = div_lat;
        pend_q = (div_divisor == 8'd0) ? 16'hFFFF : div_dividend / 16'(div_divisor);
      end
    end
  end

  // Reference HSV from plain integer arithmetic (division truncates toward zero).
  function automatic logic [23:0] ref_hsv(input int r, input int g, input int b);
    int mx, mn, d, h, s;
    mx = (r >= g && r >= b) ? r : ((g >= b) ? g : b);
    mn = (r <= g && r <= b) ? r : ((g <= b) ? g : b);
    d  = mx - mn;
    if (d == 0) return {8'd0, 8'd0, 8'(mx)};
    if (mx == r)      h = (30 * (g - b)) / d;
    else if (mx == g) h = 60 + (30 * (b - r)) / d;
    else              h = 120 + (30 * (r - g)) / d;
    if (h < 0) h = h + 180;
    s = (255 * d) / mx;
    return {8'(h), 8'(s), 8'(mx)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // driver: present a pixel (called at a negedge), return one cycle after the accept edge
  task automatic send_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                            input bit expect_out);
    int t;
    t = 0;
    din_r = r; din_g = g; din_b = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("accept_ready", in_ready, 1'b1);
    if (expect_out) exp_q.push_back(ref_hsv(r, g, b));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // collect one result; lat counts cycles with the accept cycle as cycle 0
  task automatic recv_pixel(input string tag, input int bp, output int lat);
    logic [23:0] exp, got;
    bit stable;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_sb_nonempty"}, exp_q.size() != 0, 1'b1);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 24'hx;
    got = {dout_h, dout_s, dout_v};
    chk({tag, "_hsv"}, got, exp);
    if (bp > 0) begin
      stable = 1'b1;
      repeat (bp) begin
        @(negedge clk);
        if ({dout_h, dout_s, dout_v} !== got || out_valid !== 1'b1 || in_ready !== 1'b0)
          stable = 1'b0;
      end
      chk({tag, "_hold"}, stable, 1'b1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_cnt++;
    chk({tag, "_drop"}, out_valid, 1'b0);
    chk({tag, "_pix_cnt"}, pix_cnt, 16'(exp_cnt));
  endtask

  initial begin
    int lat, n0;
    logic [7:0] r, g, b;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_outs", {out_valid, busy, err_timeout, div_start}, 4'b0);
    chk("rst_data", {dout_h, dout_s, dout_v, pix_cnt}, 40'd0);
    chk("rst_div", {div_dividend, div_divisor}, 24'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready_rise", in_ready, 1'b1);

    // saturated red, divider latency 8
    div_lat = 8;
    n0 = st_dd.size();
    send_pixel(8'd255, 8'd0, 8'd0, 1'b1);
    recv_pixel("red", 0, lat);
    chk("red_lat", lat, 2 + 1 + 8 + 1 + 8);
    chk("red_nstart", st_dd.size() - n0, 2);
    if (st_dd.size() - n0 == 2) begin
      chk("red_h_op", {st_dd[n0], st_dv[n0]}, {16'd0, 8'd255});
      chk("red_s_op", {st_dd[n0+1], st_dv[n0+1]}, {16'd65025, 8'd255});
    end

    // pure green, pure blue
    div_lat = 3;
    send_pixel(8'd0, 8'd255, 8'd0, 1'b1);
    recv_pixel("green", 0, lat);
    chk("green_h", dout_h, 8'd60);
    send_pixel(8'd0, 8'd0, 8'd128, 1'b1);
    recv_pixel("blue", 0, lat);

    // negative hue wrap
    n0 = st_dd.size();
    send_pixel(8'd255, 8'd0, 8'd64, 1'b1);
    recv_pixel("wrap", 0, lat);
    chk("wrap_h_op", {st_dd[n0], st_dv[n0]}, {16'd1920, 8'd255});

    // mid colour with 10 cycles of backpressure
    send_pixel(8'd200, 8'd100, 8'd50, 1'b1);
    recv_pixel("mid_bp", 10, lat);

    // grey: no divider access, 2-cycle latency
    n0 = st_dd.size();
    send_pixel(8'd100, 8'd100, 8'd100, 1'b1);
    recv_pixel("grey", 0, lat);
    chk("grey_lat", lat, 2);
    chk("grey_nstart", st_dd.size() - n0, 0);

    // divider never answers: timeout in WAIT_H
    div_en = 1'b0;
    n0 = st_dd.size();
    send_pixel(8'd200, 8'd100, 8'd50, 1'b0);
    exp_q.push_back({8'd0, 8'd0, 8'd200});
    recv_pixel("tmo", 0, lat);
    chk("tmo_lat", lat, 2 + 1 + 64);
    chk("tmo_err", err_timeout, 1'b1);
    chk("tmo_nstart", st_dd.size() - n0, 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_clr", err_timeout, 1'b0);
    div_en = 1'b1;

    // reset in the middle of WAIT_S; the late done must be ignored
    div_lat = 20;
    send_pixel(8'd200, 8'd100, 8'd50, 1'b0);
    repeat (30) @(negedge clk);
    chk("abort_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    chk("abort_state", {busy, out_valid, in_ready, div_start}, 4'b0);
    chk("abort_data", {dout_v, pix_cnt}, 24'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    chk("abort_idle", {busy, out_valid, in_ready}, 3'b001);
    div_lat = 2;
    send_pixel(8'd0, 8'd255, 8'd0, 1'b1);
    recv_pixel("recover", 0, lat);

    // randomized pixels, divider latency and backpressure
    for (int i = 0; i < 24; i++) begin
      r = 8'($urandom_range(0, 255));
      g = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 4) == 0) begin g = r; b = r; end
      else if ($urandom_range(0, 5) == 0) g = r;
      div_lat = $urandom_range(1, 6);
      send_pixel(r, g, b, 1'b1);
      recv_pixel($sformatf("rnd%0d", i), $urandom_range(0, 3), lat);
      chk($sformatf("rnd%0d_lat", i), lat,
          (r == g && g == b) ? 2 : 4 + 2 * div_lat);
    end

    chk("div_divisor_nonzero", bad_div, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
